// File: rtl/cg_sleep_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cg_sleep_ctrl_pkg : shared types and widths for the core sleep controller
// Revision: 1.0
// ---------------------------------------------------------------------------
package cg_sleep_ctrl_pkg;

  localparam int c_CNT_W  = 8;
  localparam int c_WAKE_W = 16;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_IDLE_WAIT = 3'd1,
    ST_GATED     = 3'd2,
    ST_ISO_ON    = 3'd3,
    ST_PWR_OFF   = 3'd4,
    ST_PWR_UP    = 3'd5,
    ST_ISO_OFF   = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cg_sleep_ctrl_dly_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cg_dly_cnt : loadable down-counter, saturating at zero, with zero flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module cg_dly_cnt
  import cg_sleep_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               i_load,
  input  logic [c_CNT_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cg_sleep_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cg_sleep_ctrl : core clock-gating / power-gating sleep sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module cg_sleep_ctrl
  import cg_sleep_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES  = 4,
  parameter int PG_DELAY     = 16,
  parameter int PWRUP_CYCLES = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                core_sleep_i,
  input  logic                outstanding_i,
  input  logic                fetch_enable_i,
  input  logic [31:0]         irq_i,
  input  logic [31:0]         irq_mask_i,
  input  logic                debug_req_i,
  input  logic                pg_allow_i,
  input  logic                pwr_ack_i,
  output logic                clk_en_o,
  output logic                iso_o,
  output logic                pwr_on_o,
  output logic                core_rst_no,
  output logic [2:0]          state_o,
  output logic [c_WAKE_W-1:0] wake_cnt_o
);

  localparam logic [c_CNT_W-1:0] c_IDLE_LD  = c_CNT_W'(IDLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_PG_LD    = c_CNT_W'(PG_DELAY - 1);
  localparam logic [c_CNT_W-1:0] c_PWRUP_LD = c_CNT_W'(PWRUP_CYCLES - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_wake;
  logic                w_cnt_load;
  logic [c_CNT_W-1:0]  w_cnt_val;
  logic                w_cnt_dec;
  logic                w_cnt_zero;
  logic                w_wake_evt;
  logic                w_clk_en;
  logic                w_iso;
  logic                w_pwr_on;
  logic                w_core_rst_n;
  logic                r_clk_en;
  logic                r_iso;
  logic                r_pwr_on;
  logic                r_core_rst_n;
  logic [c_WAKE_W-1:0] r_wake_cnt;

  assign w_wake = (|(irq_i & irq_mask_i)) | debug_req_i;

  cg_dly_cnt u_dly_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_cnt_dec   = 1'b0;
    w_wake_evt  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (core_sleep_i && !outstanding_i && fetch_enable_i && !w_wake) begin
          w_state_nxt = ST_IDLE_WAIT;
          w_cnt_load  = 1'b1;
          w_cnt_val   = c_IDLE_LD;
        end
      end
      ST_IDLE_WAIT: begin
        // Abort conditions win over the final countdown cycle.
        if (w_wake || !core_sleep_i || outstanding_i) begin
          w_state_nxt = ST_RUN;
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_GATED;
          w_cnt_load  = 1'b1;
          w_cnt_val   = c_PG_LD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_GATED: begin
        w_cnt_dec = 1'b1;
        if (w_wake) begin
          w_state_nxt = ST_RUN;
          w_wake_evt  = 1'b1;
        end else if (pg_allow_i && w_cnt_zero) begin
          w_state_nxt = ST_ISO_ON;
        end
      end
      ST_ISO_ON: begin
        if (w_wake) begin
          w_state_nxt = ST_ISO_OFF;
          w_wake_evt  = 1'b1;
        end else begin
          w_state_nxt = ST_PWR_OFF;
        end
      end
      ST_PWR_OFF: begin
        if (w_wake) begin
          w_state_nxt = ST_PWR_UP;
          w_wake_evt  = 1'b1;
          w_cnt_load  = 1'b1;
          w_cnt_val   = c_PWRUP_LD;
        end
      end
      ST_PWR_UP: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero && pwr_ack_i) begin
          w_state_nxt = ST_ISO_OFF;
        end
      end
      ST_ISO_OFF: w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs are decoded from the next state so the registers track r_state.
  always_comb begin
    w_clk_en     = 1'b0;
    w_iso        = 1'b0;
    w_pwr_on     = 1'b1;
    w_core_rst_n = 1'b1;
    case (w_state_nxt)
      ST_RUN, ST_IDLE_WAIT: w_clk_en = 1'b1;
      ST_GATED:             w_clk_en = 1'b0;
      ST_ISO_ON:            w_iso    = 1'b1;
      ST_PWR_OFF: begin
        w_iso        = 1'b1;
        w_pwr_on     = 1'b0;
        w_core_rst_n = 1'b0;
      end
      ST_PWR_UP: begin
        w_iso        = 1'b1;
        w_core_rst_n = 1'b0;
      end
      ST_ISO_OFF: w_core_rst_n = (r_state != ST_PWR_UP);
      default:    w_clk_en     = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_clk_en     <= 1'b1;
      r_iso        <= 1'b0;
      r_pwr_on     <= 1'b1;
      r_core_rst_n <= 1'b1;
      r_wake_cnt   <= '0;
    end else begin
      r_clk_en     <= w_clk_en;
      r_iso        <= w_iso;
      r_pwr_on     <= w_pwr_on;
      r_core_rst_n <= w_core_rst_n;
      if (w_wake_evt && (r_wake_cnt != '1)) begin
        r_wake_cnt <= r_wake_cnt + c_WAKE_W'(1);
      end
    end
  end

  assign clk_en_o    = r_clk_en;
  assign iso_o       = r_iso;
  assign pwr_on_o    = r_pwr_on;
  assign core_rst_no = r_core_rst_n;
  assign state_o     = r_state;
  assign wake_cnt_o  = r_wake_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cg_sleep_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cg_sleep_ctrl : scoreboard bench for the sleep controller (defaults)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cg_sleep_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_sleep_i, outstanding_i, fetch_enable_i;
  logic [31:0] irq_i, irq_mask_i;
  logic        debug_req_i, pg_allow_i, pwr_ack_i;
  logic        clk_en_o, iso_o, pwr_on_o, core_rst_no;
  logic [2:0]  state_o;
  logic [15:0] wake_cnt_o;

  always #5 clk_i = ~clk_i;

  cg_sleep_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .core_sleep_i   (core_sleep_i),
    .outstanding_i  (outstanding_i),
    .fetch_enable_i (fetch_enable_i),
    .irq_i          (irq_i),
    .irq_mask_i     (irq_mask_i),
    .debug_req_i    (debug_req_i),
    .pg_allow_i     (pg_allow_i),
    .pwr_ack_i      (pwr_ack_i),
    .clk_en_o       (clk_en_o),
    .iso_o          (iso_o),
    .pwr_on_o       (pwr_on_o),
    .core_rst_no    (core_rst_no),
    .state_o        (state_o),
    .wake_cnt_o     (wake_cnt_o)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  outs;   // {clk_en, iso, pwr_on, core_rst_n}
    logic [15:0] wc;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int ms, mcnt, mwc;
  bit mfrom_up;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_outs();
    logic [3:0] o;
    case (ms)
      0, 1:    o = 4'b1011;
      2:       o = 4'b0011;
      3:       o = 4'b0111;
      4:       o = 4'b0100;
      5:       o = 4'b0110;
      6:       o = {3'b001, ~mfrom_up};
      default: o = 4'b1011;
    endcase
    return o;
  endfunction

  task automatic model_clock();
    bit wk;
    wk = (|(irq_i & irq_mask_i)) || debug_req_i;
    case (ms)
      0: if (core_sleep_i && !outstanding_i && fetch_enable_i && !wk) begin
           ms = 1; mcnt = 3;
         end
      1: if (wk || !core_sleep_i || outstanding_i) ms = 0;
         else if (mcnt == 0) begin ms = 2; mcnt = 15; end
         else mcnt--;
      2: if (wk) begin ms = 0; if (mwc < 65535) mwc++; end
         else if (pg_allow_i && mcnt == 0) ms = 3;
         else if (mcnt > 0) mcnt--;
      3: if (wk) begin ms = 6; mfrom_up = 0; if (mwc < 65535) mwc++; end
         else ms = 4;
      4: if (wk) begin ms = 5; mcnt = 7; if (mwc < 65535) mwc++; end
      5: if (mcnt == 0 && pwr_ack_i) begin ms = 6; mfrom_up = 1; end
         else if (mcnt > 0) mcnt--;
      default: ms = 0;
    endcase
  endtask

  task automatic step();
    exp_t e, got_e;
    model_clock();
    e.st   = ms[2:0];
    e.outs = model_outs();
    e.wc   = mwc[15:0];
    q_exp.push_back(e);
    @(posedge clk_i);
    #1;
    if (q_exp.size() == 0) begin
      check_val("sb_empty", 32'(q_exp.size()), 32'd1);
    end else begin
      got_e = q_exp.pop_front();
      check_val("state", {29'd0, state_o}, {29'd0, got_e.st});
      check_val("outs", {28'd0, clk_en_o, iso_o, pwr_on_o, core_rst_no}, {28'd0, got_e.outs});
      check_val("wake_cnt", {16'd0, wake_cnt_o}, {16'd0, got_e.wc});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    ms = 0; mcnt = 0; mwc = 0; mfrom_up = 0;
    q_exp.delete();
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_state"}, {29'd0, state_o}, 32'd0);
    check_val({pfx, "_outs"}, {28'd0, clk_en_o, iso_o, pwr_on_o, core_rst_no}, 32'hB);
    check_val({pfx, "_wc"}, {16'd0, wake_cnt_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, p;
    rst_ni = 1'b0; core_sleep_i = 1'b0; outstanding_i = 1'b0; fetch_enable_i = 1'b1;
    irq_i = '0; irq_mask_i = '0; debug_req_i = 1'b0; pg_allow_i = 1'b0; pwr_ack_i = 1'b0;
    model_reset();
    #22;
    check_reset_vals("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    run(2);

    // fetch disabled blocks sleep entry
    core_sleep_i = 1'b1; fetch_enable_i = 1'b0;
    run(3);
    check_val("fe_block", {29'd0, state_o}, 32'd0);
    fetch_enable_i = 1'b1;

    // Idle countdown then clock gating held with pg disallowed
    run(5);
    check_val("gate_state", {29'd0, state_o}, 32'd2);
    check_val("gate_clk_en", {31'd0, clk_en_o}, 32'd0);
    run(20);
    check_val("gate_hold", {29'd0, state_o}, 32'd2);

    irq_i = 32'hA5A5A5A5; irq_mask_i = 32'h0;
    run(3);
    check_val("masked_irq", {29'd0, state_o}, 32'd2);
    irq_i = 32'h8; irq_mask_i = 32'h8;
    step();
    check_val("wake_clk_en", {31'd0, clk_en_o}, 32'd1);
    check_val("wake_cnt1", {16'd0, wake_cnt_o}, 32'd1);
    irq_i = '0;

    // Wake arriving on the last idle cycle
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("no_gate", {31'd0, clk_en_o}, 32'd1);
    end
    irq_i = 32'h8;
    step();
    check_val("late_wake_state", {29'd0, state_o}, 32'd0);
    check_val("late_wake_clk", {31'd0, clk_en_o}, 32'd1);
    irq_i = '0;

    // Full power-down and power-up
    pg_allow_i = 1'b1;
    run(5);
    g = 0;
    for (int i = 0; i < 40; i++) begin
      step(); g++;
      if (state_o != 3'd2) break;
    end
    check_val("gated_len", 32'(g), 32'd16);
    check_val("iso_on", {31'd0, iso_o}, 32'd1);
    pg_allow_i = 1'b0;
    step();
    check_val("pwr_off_pwr", {31'd0, pwr_on_o}, 32'd0);
    check_val("pwr_off_rst", {31'd0, core_rst_no}, 32'd0);
    run(3);
    debug_req_i = 1'b1;
    step();
    debug_req_i = 1'b0;
    check_val("pwr_up_pwr", {31'd0, pwr_on_o}, 32'd1);
    p = 1;
    irq_i = 32'h8;
    step(); if (state_o == 3'd5) p++;
    irq_i = '0;
    step(); if (state_o == 3'd5) p++;
    pwr_ack_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (state_o == 3'd5) p++;
      else break;
    end
    check_val("pwr_up_len", 32'(p), 32'd8);
    check_val("iso_off_rst", {31'd0, core_rst_no}, 32'd0);
    core_sleep_i = 1'b0;
    step();
    check_val("run_clk_en", {31'd0, clk_en_o}, 32'd1);
    check_val("run_rst", {31'd0, core_rst_no}, 32'd1);

    // Wake during ISO_ON skips power-off, core reset stays released
    core_sleep_i = 1'b1; pg_allow_i = 1'b1;
    for (int i = 0; i < 40 && ms != 3; i++) step();
    irq_i = 32'h8;
    step();
    irq_i = '0; core_sleep_i = 1'b0;
    check_val("isoon_wake_st", {29'd0, state_o}, 32'd6);
    check_val("isoon_wake_rst", {31'd0, core_rst_no}, 32'd1);
    step();

    // Asynchronous reset in the middle of power-up
    core_sleep_i = 1'b1; pwr_ack_i = 1'b0;
    for (int i = 0; i < 40 && ms != 4; i++) step();
    debug_req_i = 1'b1;
    step();
    debug_req_i = 1'b0; core_sleep_i = 1'b0;
    run(2);
    check_val("pre_areset", {29'd0, state_o}, 32'd5);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_reset_vals("areset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    run(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
